// File: rtl/flash_cmd_pkg.sv
// Shared definitions for the flash score store: Intel-style command bytes,
// status register bit positions and the state encodings of both FSMs.
package flash_cmd_pkg;

    localparam logic [7:0] CMD_READ_ARRAY   = 8'hFF;
    localparam logic [7:0] CMD_PROGRAM      = 8'h40;
    localparam logic [7:0] CMD_READ_STATUS  = 8'h70;
    localparam logic [7:0] CMD_CLEAR_STATUS = 8'h50;

    localparam int SR_READY   = 7;
    localparam int SR_PRG_ERR = 4;
    localparam int SR_VPP_ERR = 3;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        L_ARRAY = 4'd1,
        L_READ  = 4'd2,
        S_SETUP = 4'd3,
        S_DATA  = 4'd4,
        S_STCMD = 4'd5,
        S_POLL  = 4'd6,
        S_CLR   = 4'd7,
        S_NEXT  = 4'd8,
        FIN     = 4'd9,
        V_READ  = 4'd10
    } main_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2
    } bus_state_e;

    // A ready status word reports failure through either error bit.
    function automatic logic status_failed(input logic [7:0] status);
        return status[SR_PRG_ERR] | status[SR_VPP_ERR];
    endfunction

endpackage

// File: rtl/flash_bus_op.sv
// Single bridge transaction: latches address/data/direction on op_go,
// raises fb_start one cycle later and holds it until fb_done is sampled.
module flash_bus_op
    import flash_cmd_pkg::*;
(
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       op_go,
    input  logic       op_rd,
    input  logic [7:0] op_addr,
    input  logic [7:0] op_wdata,
    output logic       op_done,
    output logic [7:0] op_rdata,
    output logic [7:0] fb_addr,
    output logic [7:0] fb_wdata,
    output logic       fb_dir_rw,
    output logic       fb_start,
    input  logic       fb_done,
    input  logic [7:0] fb_rdata
);

    bus_state_e bus_state_r;
    logic [7:0] addr_r;
    logic [7:0] wdata_r;
    logic       dir_rw_r;
    logic       start_r;
    logic       op_done_r;
    logic [7:0] rdata_r;

    // Handshake sequencer; the bus registers only change while no op is in flight.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            bus_state_r <= BUS_IDLE;
            addr_r      <= 8'h00;
            wdata_r     <= 8'h00;
            dir_rw_r    <= 1'b1;
            start_r     <= 1'b0;
            op_done_r   <= 1'b0;
            rdata_r     <= 8'h00;
        end else begin
            op_done_r <= 1'b0;
            case (bus_state_r)
                BUS_IDLE: begin
                    if (op_go) begin
                        addr_r      <= op_addr;
                        wdata_r     <= op_wdata;
                        dir_rw_r    <= op_rd;
                        bus_state_r <= BUS_REQ;
                    end
                end
                BUS_REQ: begin
                    start_r     <= 1'b1;
                    bus_state_r <= BUS_WAIT;
                end
                BUS_WAIT: begin
                    if (fb_done) begin
                        start_r     <= 1'b0;
                        rdata_r     <= fb_rdata;
                        op_done_r   <= 1'b1;
                        bus_state_r <= BUS_IDLE;
                    end
                end
                default: begin
                    start_r     <= 1'b0;
                    bus_state_r <= BUS_IDLE;
                end
            endcase
        end
    end

    assign fb_addr   = addr_r;
    assign fb_wdata  = wdata_r;
    assign fb_dir_rw = dir_rw_r;
    assign fb_start  = start_r;
    assign op_done   = op_done_r;
    assign op_rdata  = rdata_r;

endmodule

// File: rtl/flash_score_store.sv
// Scoreboard byte bank backed by parallel NOR flash. A load pulse fills the
// bank from flash; a store pulse programs it byte by byte with status polling.
// Optional build macro FLASH_STORE_VERIFY_EN adds a read-back compare after a
// clean store.
module flash_score_store
    import flash_cmd_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'h00,
    parameter int         NUM_BYTES  = 8,
    parameter int         POLL_LIMIT = 255
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       req_load,
    input  logic       req_store,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_data,
    output logic [7:0] fb_addr,
    output logic [7:0] fb_wdata,
    input  logic [7:0] fb_rdata,
    output logic       fb_dir_rw,
    output logic       fb_start,
    input  logic       fb_done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);
    localparam logic [4:0] DEPTH    = 5'(NUM_BYTES);
    localparam logic [8:0] POLL_MAX = 9'(POLL_LIMIT);

    main_state_e state_r;
    logic [3:0]  idx_r;
    logic [8:0]  poll_cnt_r;
    logic        issued_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;
    logic [7:0]  bank_r [16];

    logic        need_op_s;
    logic        op_rd_s;
    logic [7:0]  op_addr_s;
    logic [7:0]  op_wdata_s;
    logic        go_s;
    logic        op_done_s;
    logic [7:0]  op_rdata_s;
    logic [7:0]  byte_addr_s;
    logic        last_s;
    logic [7:0]  rd_data_s;

    assign byte_addr_s = BASE_ADDR + {4'd0, idx_r};
    assign last_s      = (idx_r == LAST_IDX);
    assign go_s        = need_op_s & ~issued_r;

    // Bus operation implied by the current main state (one op per state visit).
    always_comb begin
        need_op_s  = 1'b0;
        op_rd_s    = 1'b0;
        op_addr_s  = byte_addr_s;
        op_wdata_s = 8'h00;
        case (state_r)
            L_ARRAY: begin
                need_op_s  = 1'b1;
                op_addr_s  = BASE_ADDR;
                op_wdata_s = CMD_READ_ARRAY;
            end
            L_READ: begin
                need_op_s = 1'b1;
                op_rd_s   = 1'b1;
            end
            S_SETUP: begin
                need_op_s  = 1'b1;
                op_wdata_s = CMD_PROGRAM;
            end
            S_DATA: begin
                need_op_s  = 1'b1;
                op_wdata_s = bank_r[idx_r];
            end
            S_STCMD: begin
                need_op_s  = 1'b1;
                op_wdata_s = CMD_READ_STATUS;
            end
            S_POLL: begin
                need_op_s = 1'b1;
                op_rd_s   = 1'b1;
            end
            S_CLR: begin
                need_op_s  = 1'b1;
                op_wdata_s = CMD_CLEAR_STATUS;
            end
            FIN: begin
                need_op_s  = 1'b1;
                op_addr_s  = BASE_ADDR;
                op_wdata_s = CMD_READ_ARRAY;
            end
            V_READ: begin
                need_op_s = 1'b1;
                op_rd_s   = 1'b1;
            end
            default: begin
                need_op_s = 1'b0;
            end
        endcase
    end

    // Main sequencer: request acceptance, load/store/verify flow, bank and flags.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state_r    <= IDLE;
            idx_r      <= 4'd0;
            poll_cnt_r <= 9'd0;
            issued_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                bank_r[i] <= 8'h00;
            end
        end else begin
            done_r <= 1'b0;
            if (go_s) begin
                issued_r <= 1'b1;
            end
            if (wr_en && !busy_r && ({1'b0, wr_idx} < DEPTH)) begin
                bank_r[wr_idx] <= wr_data;
            end
            case (state_r)
                IDLE: begin
                    issued_r <= 1'b0;
                    if (req_load) begin
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
                        idx_r   <= 4'd0;
                        state_r <= L_ARRAY;
                    end else if (req_store) begin
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
                        idx_r   <= 4'd0;
                        state_r <= S_SETUP;
                    end
                end
                L_ARRAY: begin
                    if (op_done_s) begin
                        issued_r <= 1'b0;
                        state_r  <= L_READ;
                    end
                end
                L_READ: begin
                    if (op_done_s) begin
                        issued_r      <= 1'b0;
                        bank_r[idx_r] <= op_rdata_s;
                        if (last_s) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                end
                S_SETUP: begin
                    if (op_done_s) begin
                        issued_r <= 1'b0;
                        state_r  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (op_done_s) begin
                        issued_r <= 1'b0;
                        state_r  <= S_STCMD;
                    end
                end
                S_STCMD: begin
                    if (op_done_s) begin
                        issued_r   <= 1'b0;
                        poll_cnt_r <= 9'd0;
                        state_r    <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (op_done_s) begin
                        issued_r   <= 1'b0;
                        poll_cnt_r <= poll_cnt_r + 9'd1;
                        if (op_rdata_s[SR_READY]) begin
                            if (status_failed(op_rdata_s)) begin
                                error_r <= 1'b1;
                                state_r <= S_CLR;
                            end else begin
                                state_r <= S_NEXT;
                            end
                        end else if (poll_cnt_r + 9'd1 == POLL_MAX) begin
                            error_r <= 1'b1;
                            state_r <= S_CLR;
                        end
                    end
                end
                S_NEXT: begin
                    if (last_s) begin
                        state_r <= S_CLR;
                    end else begin
                        idx_r   <= idx_r + 4'd1;
                        state_r <= S_SETUP;
                    end
                end
                S_CLR: begin
                    if (op_done_s) begin
                        issued_r <= 1'b0;
                        state_r  <= FIN;
                    end
                end
                FIN: begin
                    if (op_done_s) begin
                        issued_r <= 1'b0;
`ifdef FLASH_STORE_VERIFY_EN
                        if (!error_r) begin
                            idx_r   <= 4'd0;
                            state_r <= V_READ;
                        end else begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end
`else
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
`endif
                    end
                end
                V_READ: begin
                    if (op_done_s) begin
                        issued_r <= 1'b0;
                        if (op_rdata_s != bank_r[idx_r]) begin
                            error_r <= 1'b1;
                        end
                        if (last_s) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                end
                default: begin
                    issued_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Host read port; indices beyond the bank depth read as zero.
    always_comb begin
        if ({1'b0, rd_idx} < DEPTH) begin
            rd_data_s = bank_r[rd_idx];
        end else begin
            rd_data_s = 8'h00;
        end
    end

    flash_bus_op u_bus_op (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .op_go     (go_s),
        .op_rd     (op_rd_s),
        .op_addr   (op_addr_s),
        .op_wdata  (op_wdata_s),
        .op_done   (op_done_s),
        .op_rdata  (op_rdata_s),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .fb_dir_rw (fb_dir_rw),
        .fb_start  (fb_start),
        .fb_done   (fb_done),
        .fb_rdata  (fb_rdata)
    );

    assign busy    = busy_r;
    assign done    = done_r;
    assign error   = error_r;
    assign rd_data = rd_data_s;

endmodule

// File: tb/tb_flash_score_store.sv
// Randomized bench for flash_score_store with a behavioural NOR flash model
// acting as the bridge responder (fb_done three cycles after fb_start).
module tb_flash_score_store;

    localparam int         NB   = 4;
    localparam int         PL   = 5;
    localparam logic [7:0] BASE = 8'h00;

    logic       CLK_50MHZ = 1'b0;
    logic       RST;
    logic       req_load, req_store, busy, done, error;
    logic       wr_en;
    logic [3:0] wr_idx, rd_idx;
    logic [7:0] wr_data, rd_data;
    logic [7:0] fb_addr, fb_wdata, fb_rdata;
    logic       fb_dir_rw, fb_start, fb_done;

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    flash_score_store #(.BASE_ADDR(BASE), .NUM_BYTES(NB), .POLL_LIMIT(PL)) dut (
        .CLK_50MHZ(CLK_50MHZ), .RST(RST), .req_load(req_load), .req_store(req_store),
        .busy(busy), .done(done), .error(error), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .rd_idx(rd_idx), .rd_data(rd_data), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .fb_rdata(fb_rdata), .fb_dir_rw(fb_dir_rw),
        .fb_start(fb_start), .fb_done(fb_done)
    );

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } op_t;

    op_t        log_q[$];
    op_t        exp_q[$];
    logic [7:0] mem [256];
    logic [7:0] bank_m [NB];
    logic [7:0] status_val;
    logic [7:0] corrupt_addr;
    bit         stat_mode, prog_pend, corrupt_en;
    int         resp_cnt;
    logic [7:0] cap_addr;
    int         done_cnt;
    int         n_checks;
    int         n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash behaviour for one completed bridge op.
    task automatic serve();
        op_t o;
        o.rd   = fb_dir_rw;
        o.addr = fb_addr;
        if (fb_dir_rw) begin
            o.data   = stat_mode ? status_val : mem[fb_addr];
            fb_rdata = o.data;
        end else begin
            o.data = fb_wdata;
            if (prog_pend) begin
                mem[fb_addr] = (corrupt_en && fb_addr == corrupt_addr) ? (fb_wdata ^ 8'h01) : fb_wdata;
                prog_pend = 1'b0;
                stat_mode = 1'b1;
            end else if (fb_wdata == 8'hFF) stat_mode = 1'b0;
            else if (fb_wdata == 8'h40) prog_pend = 1'b1;
            else if (fb_wdata == 8'h70) stat_mode = 1'b1;
        end
        log_q.push_back(o);
    endtask

    // One clock cycle: the responder acts on the falling edge.
    task automatic cyc();
        @(negedge CLK_50MHZ);
        if (done) done_cnt++;
        if (fb_done) begin
            fb_done = 1'b0;
            check("start_drop", {31'd0, fb_start}, 32'd0);
        end else if (resp_cnt == 0) begin
            if (fb_start) begin
                resp_cnt = 1;
                cap_addr = fb_addr;
            end
        end else if (resp_cnt < 3) begin
            resp_cnt++;
        end else begin
            resp_cnt = 0;
            check("addr_stable", fb_addr, cap_addr);
            serve();
            fb_done = 1'b1;
        end
    endtask

    task automatic exp_op(input logic rd, input logic [7:0] a, input logic [7:0] d);
        op_t o;
        o.rd = rd; o.addr = a; o.data = d;
        exp_q.push_back(o);
    endtask

    task automatic host_write(input int i, input logic [7:0] d);
        wr_en = 1'b1; wr_idx = 4'(i); wr_data = d;
        cyc();
        wr_en = 1'b0;
        bank_m[i] = d;
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NB; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("%s_bank%0d", tag, i), rd_data, bank_m[i]);
        end
    endtask

    // Issue a request, wait (bounded) for done, then compare the op log.
    task automatic run(input bit ld, input bit st, input bit poke_req, input bit poke_wr, input string tag);
        int d0;
        log_q.delete();
        d0 = done_cnt;
        req_load = ld; req_store = st;
        cyc();
        req_load = 1'b0; req_store = 1'b0;
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
            req_store = poke_req && (k == 5);
            if (poke_wr && k == 5) begin
                wr_en = 1'b1; wr_idx = 4'd1; wr_data = ~bank_m[1];
            end else begin
                wr_en = 1'b0;
            end
            cyc();
        end
        req_store = 1'b0; wr_en = 1'b0;
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        for (int k = 0; k < 12; k++) cyc();
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_op_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_op%0d", tag, i), log_q[i], exp_q[i]);
        exp_q.delete();
    endtask

    task automatic do_load(input string tag);
        exp_op(1'b0, BASE, 8'hFF);
        for (int i = 0; i < NB; i++) begin
            exp_op(1'b1, BASE + 8'(i), mem[BASE + 8'(i)]);
            bank_m[i] = mem[BASE + 8'(i)];
        end
        run(1'b1, 1'b0, 1'b0, 1'b0, tag);
        check_bank(tag);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    // Clean store; cidx names the byte the flash model corrupts (-1 for none).
    task automatic do_store_ok(input int cidx, input bit poke_wr, input string tag);
        logic [7:0] a;
        status_val = 8'h80;
        for (int i = 0; i < NB; i++) begin
            a = BASE + 8'(i);
            exp_op(1'b0, a, 8'h40);
            exp_op(1'b0, a, bank_m[i]);
            exp_op(1'b0, a, 8'h70);
            exp_op(1'b1, a, 8'h80);
        end
        exp_op(1'b0, BASE + 8'(NB - 1), 8'h50);
        exp_op(1'b0, BASE, 8'hFF);
`ifdef FLASH_STORE_VERIFY_EN
        for (int i = 0; i < NB; i++)
            exp_op(1'b1, BASE + 8'(i), (i == cidx) ? (bank_m[i] ^ 8'h01) : bank_m[i]);
`endif
        corrupt_en   = (cidx >= 0);
        corrupt_addr = BASE + 8'(cidx);
        run(1'b0, 1'b1, 1'b0, poke_wr, tag);
        corrupt_en = 1'b0;
        for (int i = 0; i < NB; i++)
            check($sformatf("%s_mem%0d", tag, i), mem[BASE + 8'(i)],
                  (i == cidx) ? (bank_m[i] ^ 8'h01) : bank_m[i]);
        check_bank(tag);
`ifdef FLASH_STORE_VERIFY_EN
        check({tag, "_error"}, {31'd0, error}, {31'd0, cidx >= 0});
`else
        check({tag, "_error"}, {31'd0, error}, 32'd0);
`endif
    endtask

    // Store whose first byte fails: npolls status reads of value st.
    task automatic do_store_fail(input logic [7:0] st, input int nplls, input string tag);
        status_val = st;
        exp_op(1'b0, BASE, 8'h40);
        exp_op(1'b0, BASE, bank_m[0]);
        exp_op(1'b0, BASE, 8'h70);
        for (int i = 0; i < nplls; i++) exp_op(1'b1, BASE, st);
        exp_op(1'b0, BASE, 8'h50);
        exp_op(1'b0, BASE, 8'hFF);
        run(1'b0, 1'b1, 1'b0, 1'b0, tag);
        check({tag, "_error"}, {31'd0, error}, 32'd1);
    endtask

    initial begin
        logic found;
        n_checks = 0; n_errors = 0; done_cnt = 0; resp_cnt = 0;
        stat_mode = 1'b0; prog_pend = 1'b0; corrupt_en = 1'b0;
        corrupt_addr = 8'h00; status_val = 8'h80; cap_addr = 8'h00;
        RST = 1'b0; req_load = 1'b0; req_store = 1'b0;
        wr_en = 1'b0; wr_idx = 4'd0; wr_data = 8'h00; rd_idx = 4'd0;
        fb_done = 1'b0; fb_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < NB; i++) bank_m[i] = 8'h00;

        repeat (3) cyc();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_fb_start", {31'd0, fb_start}, 32'd0);
        check("rst_fb_addr", fb_addr, 8'h00);
        check("rst_fb_wdata", fb_wdata, 8'h00);
        check("rst_fb_dir_rw", {31'd0, fb_dir_rw}, 32'd1);
        check_bank("rst");
        RST = 1'b1;
        repeat (3) cyc();

        // Load of a known pattern, then a random one.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        do_load("load_fixed");
        for (int i = 0; i < NB; i++) mem[BASE + 8'(i)] = 8'($urandom_range(0, 255));
        do_load("load_rand");

        // Store: A5 in byte 0, random elsewhere; second round pokes wr_en while busy.
        host_write(0, 8'hA5);
        for (int i = 1; i < NB; i++) host_write(i, 8'($urandom_range(0, 255)));
        do_store_ok(-1, 1'b0, "store_a5");
        for (int i = 0; i < NB; i++) host_write(i, 8'($urandom_range(0, 255)));
        do_store_ok(-1, 1'b1, "store_rand");

        // Status never ready: timeout after exactly PL reads, remaining bytes skipped.
        host_write(0, 8'($urandom_range(0, 255)));
        do_store_fail(8'h00, PL, "store_timeout");
        do_load("load_clears_err");

        // Ready with a program or Vpp error bit.
        do_store_fail(($urandom_range(0, 1) == 0) ? 8'h90 : 8'h88, 1, "store_prgerr");

        // Simultaneous requests: load wins; a store during busy is ignored.
        for (int i = 0; i < NB; i++) mem[BASE + 8'(i)] = 8'($urandom_range(0, 255));
        exp_op(1'b0, BASE, 8'hFF);
        for (int i = 0; i < NB; i++) begin
            exp_op(1'b1, BASE + 8'(i), mem[BASE + 8'(i)]);
            bank_m[i] = mem[BASE + 8'(i)];
        end
        run(1'b1, 1'b1, 1'b1, 1'b0, "both_req");
        check_bank("both_req");

        // Reset while a store op is waiting on the bridge.
        status_val = 8'h80;
        req_store = 1'b1;
        cyc();
        req_store = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc();
            found = (resp_cnt > 0);
        end
        check("midrst_wait_seen", {31'd0, found}, 32'd1);
        RST = 1'b0;
        fb_done = 1'b0; resp_cnt = 0; stat_mode = 1'b0; prog_pend = 1'b0;
        #1;
        check("midrst_fb_start", {31'd0, fb_start}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < NB; i++) bank_m[i] = 8'h00;
        check_bank("midrst");
        repeat (2) cyc();
        RST = 1'b1;
        repeat (2) cyc();
        for (int i = 0; i < NB; i++) mem[BASE + 8'(i)] = 8'($urandom_range(0, 255));
        do_load("load_after_rst");

        // Flash corrupts byte 2 during programming.
        for (int i = 0; i < NB; i++) host_write(i, 8'($urandom_range(0, 255)));
        do_store_ok(2, 1'b0, "store_corrupt");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
